// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler slice.
//   sched_state_t : scheduler FSM state encoding (IDLE/LOAD/SEND/RELEASE)
//   BIT_TMR_MAX   : clocks per serial bit of the board transmitter
//   BIT_IDX_MAX   : bits per 8N1 character (start + 8 data + stop)
//   idx_width()   : index width for a requester count (minimum 1 bit)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SEND    = 2'd2,
        ST_RELEASE = 2'd3
    } sched_state_t;

    localparam int BIT_TMR_MAX = 869;
    localparam int BIT_IDX_MAX = 10;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational rotate-priority picker: finds the first asserted request
// scanning ptr, ptr+1, ... modulo NUM_REQ.
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    highest-priority position (always < NUM_REQ)
//   found out 1        at least one request asserted
//   idx   out IDX_W    index of the winning requester (0 when none)
// ---------------------------------------------------------------------------
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // w_pos[k] is the requester index examined at priority rank k.
    logic [IDX_W-1:0]   w_pos [NUM_REQ];
    logic [NUM_REQ-1:0] w_rot;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [IDX_W:0] w_sum;
            // ptr < NUM_REQ, so a single conditional subtraction wraps.
            assign w_sum      = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign w_pos[gi]  = (w_sum >= (IDX_W+1)'(NUM_REQ))
                              ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                              : w_sum[IDX_W-1:0];
            assign w_rot[gi]  = req[w_pos[gi]];
        end
    endgenerate

    // Scan from lowest priority upward so the highest-priority hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                found = 1'b1;
                idx   = w_pos[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Round-robin scheduler sharing one byte-level 8N1 UART transmitter
// (send/done handshake) between NUM_REQ frame-oriented requesters. A grant
// lasts a whole frame (or MAX_BYTES bytes); each byte is registered so it is
// stable on the wire; a per-byte watchdog recovers from a stuck transmitter.
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   req          in   NUM_REQ    per-requester byte available
//   req_data     in   8*NUM_REQ  byte of requester i at [8i+7:8i]
//   req_last     in   NUM_REQ    presented byte ends the frame
//   byte_ack     out  NUM_REQ    one-cycle pulse: byte of requester i taken
//   grant        out  NUM_REQ    one-hot line owner, 0 when idle
//   tx_send      out  transmitter send
//   tx_data      out  8          transmitter data
//   tx_done      in   transmitter done
//   busy         out  scheduler not idle
//   err_timeout  out  one-cycle pulse on watchdog expiry
// ---------------------------------------------------------------------------
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BYTES = 16,
    parameter int TIMEOUT   = 16383
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     byte_ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   tx_send,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   busy,
    output logic                   err_timeout
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BYTES + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    sched_state_t       r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_g;
    logic [IDX_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_last;
    logic               r_abort;
    logic [7:0]         r_tx_data;

    logic               w_found;
    logic [IDX_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_g_onehot;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [7:0]         w_req_byte [NUM_REQ];
    logic [7:0]         w_sel_byte;
    logic               w_sel_req;
    logic               w_sel_last;
    logic [IDX_W-1:0]   w_next_ptr;
    logic               w_cap_hit;
    logic               w_tmo_hit;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
            assign w_g_onehot[gi]   = (r_g == IDX_W'(gi));
            assign w_win_onehot[gi] = (w_idx == IDX_W'(gi));
            assign w_req_byte[gi]   = req_data[8*gi +: 8];
        end
    endgenerate

    assign w_sel_req  = req[r_g];
    assign w_sel_last = req_last[r_g];
    assign w_sel_byte = w_req_byte[r_g];
    assign w_next_ptr = (r_g == IDX_W'(NUM_REQ - 1)) ? '0 : r_g + 1'b1;
    // Cap is evaluated before the increment: this byte is number cnt+1.
    assign w_cap_hit  = (r_cnt == CNT_W'(MAX_BYTES - 1));
    assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_g       <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_last    <= 1'b0;
            r_abort   <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_win_onehot;
                        r_g     <= w_idx;
                        r_cnt   <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_sel_req) begin
                        r_tx_data <= w_sel_byte;
                        r_last    <= w_sel_last | w_cap_hit;
                        r_cnt     <= r_cnt + 1'b1;
                        r_tmo     <= '0;
                        r_state   <= ST_SEND;
                    end else begin
                        // Requester vanished mid-frame: give the line away.
                        r_grant <= '0;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (tx_done) begin
                        r_state <= ST_RELEASE;
                    end else if (w_tmo_hit) begin
                        r_abort <= 1'b1;
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Hold off until done falls so the transmitter is ready again.
                    if (!tx_done) begin
                        if (r_last || r_abort) begin
                            r_grant <= '0;
                            r_ptr   <= w_next_ptr;
                            r_abort <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Pulses are gated by rst so an interrupted frame emits nothing.
    assign byte_ack    = (r_state == ST_LOAD && w_sel_req && !rst) ? w_g_onehot : '0;
    assign err_timeout = (r_state == ST_SEND) && !tx_done && w_tmo_hit && !rst;
    assign tx_send     = (r_state == ST_SEND);
    assign tx_data     = r_tx_data;
    assign grant       = r_grant;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BYTES = 16;
    localparam int TIMEOUT   = 16383;
    localparam int DEPTH     = 64;
    localparam int MODE_SERIAL = 0;
    localparam int MODE_STUB   = 1;
    localparam int MODE_DEAD   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   byte_ack;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_send;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic                 busy;
    logic                 err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_sched #(
        .NUM_REQ   (NUM_REQ),
        .MAX_BYTES (MAX_BYTES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .byte_ack    (byte_ack),
        .grant       (grant),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // ---------------- transmitter model ----------------
    int   tx_mode  = MODE_STUB;
    int   stub_lat = 2;
    logic tx_line;
    logic m_active;
    int   m_cnt, m_bit, stub_cnt;
    logic [9:0] m_shift;

    always @(posedge clk) begin
        if (rst) begin
            tx_done  <= 1'b0;
            tx_line  <= 1'b1;
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_bit    <= 0;
            stub_cnt <= 0;
        end else if (tx_mode == MODE_SERIAL) begin
            if (!m_active) begin
                if (tx_done) begin
                    if (!tx_send) tx_done <= 1'b0;
                end else if (tx_send) begin
                    m_active <= 1'b1;
                    m_shift  <= {1'b1, tx_data, 1'b0};
                    m_cnt    <= 0;
                    m_bit    <= 0;
                    tx_line  <= 1'b0;
                end
            end else if (m_cnt == BIT_TMR_MAX - 1) begin
                m_cnt <= 0;
                if (m_bit == BIT_IDX_MAX - 1) begin
                    m_active <= 1'b0;
                    tx_done  <= 1'b1;
                    tx_line  <= 1'b1;
                end else begin
                    m_bit   <= m_bit + 1;
                    tx_line <= m_shift[m_bit+1];
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (tx_mode == MODE_STUB) begin
            if (tx_done) begin
                if (!tx_send) tx_done <= 1'b0;
            end else if (tx_send) begin
                if (stub_cnt >= stub_lat) begin
                    tx_done  <= 1'b1;
                    stub_cnt <= 0;
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end
        end
    end

    // ---------------- serial line decoder ----------------
    logic [7:0] rx_log [$];

    initial begin : rx_dec
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_mode == MODE_SERIAL && !rst && tx_line == 1'b0) begin
                repeat (BIT_TMR_MAX / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (BIT_TMR_MAX) @(negedge clk);
                    b[k] = tx_line;
                end
                repeat (BIT_TMR_MAX) @(negedge clk);
                rx_log.push_back(b);
            end
        end
    end

    // ---------------- requester sources ----------------
    logic [7:0] src_data [NUM_REQ][DEPTH];
    logic       src_last [NUM_REQ][DEPTH];
    int         src_head [NUM_REQ];
    int         src_tail [NUM_REQ];
    logic       flush_req = 1'b0;

    initial begin : req_model
        logic [NUM_REQ-1:0] ack_s;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        req = '0; req_data = '0; req_last = '0;
        forever begin
            @(negedge clk);
            ack_s = byte_ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush_req) src_head[i] = src_tail[i];
                else if (ack_s[i] && src_head[i] < src_tail[i]) src_head[i]++;
                req[i]            = (src_head[i] < src_tail[i]);
                req_data[8*i +: 8] = src_data[i][src_head[i]];
                req_last[i]       = src_last[i][src_head[i]];
            end
        end
    end

    // ---------------- monitor ----------------
    int               ack_idx_log [$];
    logic [7:0]       ack_data_log [$];
    logic [NUM_REQ-1:0] grant_log [$];
    int               drop_log [$];
    int               gap_log [$];
    int               ack_total = 0;
    int               multi_grant = 0;
    int               data_unstable = 0;

    initial begin : monitor
        logic [NUM_REQ-1:0] prev_grant;
        logic       prev_send;
        logic [7:0] prev_data;
        int         gap_cnt;
        bit         in_gap;
        prev_grant = '0; prev_send = 1'b0; prev_data = 8'h00; gap_cnt = 0; in_gap = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (byte_ack[i]) begin
                        ack_idx_log.push_back(i);
                        ack_data_log.push_back(req_data[8*i +: 8]);
                        ack_total++;
                    end
                end
                if (grant != prev_grant) begin
                    if (grant != '0) grant_log.push_back(grant);
                    else drop_log.push_back(ack_total);
                end
                if ($countones(grant) > 1) multi_grant++;
                if (tx_send && prev_send && tx_data != prev_data) data_unstable++;
                if (tx_send && !prev_send) begin
                    if (in_gap) gap_log.push_back(gap_cnt);
                    in_gap  = 1;
                    gap_cnt = 0;
                end else if (!tx_send && busy && in_gap) begin
                    gap_cnt++;
                end
                if (!busy) in_gap = 0;
            end
            prev_grant = grant;
            prev_send  = tx_send;
            prev_data  = tx_data;
        end
    end

    // ---------------- helpers ----------------
    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        src_data[r][src_tail[r]] = d;
        src_last[r][src_tail[r]] = l;
        src_tail[r]++;
    endtask

    function automatic bit sources_empty();
        for (int i = 0; i < NUM_REQ; i++)
            if (src_head[i] != src_tail[i]) return 0;
        return 1;
    endfunction

    task automatic clear_logs();
        ack_idx_log.delete(); ack_data_log.delete(); grant_log.delete();
        drop_log.delete(); gap_log.delete(); rx_log.delete();
        ack_total = 0; multi_grant = 0; data_unstable = 0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sources_empty() && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_errors++;
            $display("FAIL %s_done: still busy after %0d cycles, required idle", name, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        flush_req = 1'b1;
        @(posedge clk);
        #2;
        flush_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (grant !== 4'b0000) begin n_errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_checks++; if (byte_ack !== 4'b0000) begin n_errors++; $display("FAIL reset_ack: got %b want 0000", byte_ack); end
        n_checks++; if (tx_send !== 1'b0) begin n_errors++; $display("FAIL reset_send: got %b want 0", tx_send); end
        n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h want 00", tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_idle_after: busy %b want 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        int n;
        tx_mode = MODE_SERIAL;
        clear_logs();
        @(negedge clk);
        push_byte(0, 8'hA5, 1'b0);
        push_byte(0, 8'h3C, 1'b0);
        push_byte(0, 8'h81, 1'b1);
        n = 0;
        while (grant == '0 && n < 20) begin @(negedge clk); n++; end
        n_checks++; if (grant !== 4'b0001) begin n_errors++; $display("FAIL sf_grant: got %b want 0001", grant); end
        n_checks++; if (byte_ack !== 4'b0001) begin n_errors++; $display("FAIL sf_first_ack: got %b want 0001", byte_ack); end
        n_checks++; if (tx_send !== 1'b0) begin n_errors++; $display("FAIL sf_send_in_load: got %b want 0", tx_send); end
        @(negedge clk);
        n_checks++; if (tx_send !== 1'b1) begin n_errors++; $display("FAIL sf_send_next: got %b want 1", tx_send); end
        n_checks++; if (tx_data !== 8'hA5) begin n_errors++; $display("FAIL sf_txdata: got %h want a5", tx_data); end
        wait_done(40000, "sf");
        n_checks++; if (ack_idx_log.size() != 3) begin n_errors++; $display("FAIL sf_ack_count: got %0d want 3", ack_idx_log.size()); end
        for (int i = 0; i < ack_idx_log.size(); i++) begin
            n_checks++;
            if (ack_idx_log[i] != 0) begin n_errors++; $display("FAIL sf_ack_idx%0d: got %0d want 0", i, ack_idx_log[i]); end
        end
        n_checks++;
        if (rx_log.size() != 3) begin n_errors++; $display("FAIL sf_rx_count: got %0d want 3", rx_log.size()); end
        else begin
            n_checks++; if (rx_log[0] !== 8'hA5) begin n_errors++; $display("FAIL sf_rx0: got %h want a5", rx_log[0]); end
            n_checks++; if (rx_log[1] !== 8'h3C) begin n_errors++; $display("FAIL sf_rx1: got %h want 3c", rx_log[1]); end
            n_checks++; if (rx_log[2] !== 8'h81) begin n_errors++; $display("FAIL sf_rx2: got %h want 81", rx_log[2]); end
        end
        n_checks++;
        if (gap_log.size() != 2) begin n_errors++; $display("FAIL sf_gap_count: got %0d want 2", gap_log.size()); end
        else begin
            n_checks++; if (gap_log[0] != 3 || gap_log[1] != 3) begin n_errors++; $display("FAIL sf_gap: got %0d,%0d want 3,3", gap_log[0], gap_log[1]); end
        end
        n_checks++; if (data_unstable != 0) begin n_errors++; $display("FAIL sf_data_stable: %0d changes want 0", data_unstable); end
        n_checks++; if (grant !== 4'b0000) begin n_errors++; $display("FAIL sf_grant_end: got %b want 0000", grant); end
        // Pointer must now be 1: with 0 and 1 both asking, 1 goes first.
        tx_mode = MODE_STUB;
        clear_logs();
        push_byte(0, 8'hAA, 1'b1);
        push_byte(1, 8'hBB, 1'b1);
        wait_done(200, "sf_ptr");
        n_checks++;
        if (grant_log.size() != 2) begin n_errors++; $display("FAIL sf_ptr_grants: got %0d grants want 2", grant_log.size()); end
        else begin
            n_checks++; if (grant_log[0] !== 4'b0010) begin n_errors++; $display("FAIL sf_ptr_first: got %b want 0010", grant_log[0]); end
            n_checks++; if (grant_log[1] !== 4'b0001) begin n_errors++; $display("FAIL sf_ptr_second: got %b want 0001", grant_log[1]); end
        end
        $display("test_single_frame done");
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_g [4];
        logic [7:0]         exp_d [4];
        exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010; exp_g[3] = 4'b1000;
        exp_d[0] = 8'h11;   exp_d[1] = 8'h31;   exp_d[2] = 8'h12;   exp_d[3] = 8'h32;
        reset_dut();
        tx_mode = MODE_STUB;
        clear_logs();
        push_byte(1, 8'h11, 1'b1);
        push_byte(1, 8'h12, 1'b1);
        push_byte(3, 8'h31, 1'b1);
        push_byte(3, 8'h32, 1'b1);
        wait_done(300, "rr");
        n_checks++;
        if (grant_log.size() != 4 || ack_data_log.size() != 4) begin
            n_errors++;
            $display("FAIL rr_count: got %0d grants %0d acks want 4 4", grant_log.size(), ack_data_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (grant_log[i] !== exp_g[i]) begin n_errors++; $display("FAIL rr_grant%0d: got %b want %b", i, grant_log[i], exp_g[i]); end
                n_checks++;
                if (ack_data_log[i] !== exp_d[i]) begin n_errors++; $display("FAIL rr_data%0d: got %h want %h", i, ack_data_log[i], exp_d[i]); end
            end
        end
        n_checks++; if (multi_grant != 0) begin n_errors++; $display("FAIL rr_onehot: %0d multi-bit grant cycles want 0", multi_grant); end
        $display("test_round_robin done");
    endtask

    task automatic test_max_bytes();
        tx_mode = MODE_STUB;
        clear_logs();
        @(negedge clk);
        for (int k = 0; k < 20; k++) push_byte(2, 8'h40 + 8'(k), 1'b0);
        wait_done(1000, "cap");
        n_checks++;
        if (ack_data_log.size() != 20) begin n_errors++; $display("FAIL cap_acks: got %0d want 20", ack_data_log.size()); end
        else begin
            for (int k = 0; k < 20; k++) begin
                n_checks++;
                if (ack_data_log[k] !== 8'h40 + 8'(k) || ack_idx_log[k] != 2) begin
                    n_errors++;
                    $display("FAIL cap_byte%0d: got r%0d %h want r2 %h", k, ack_idx_log[k], ack_data_log[k], 8'h40 + 8'(k));
                end
            end
        end
        n_checks++;
        if (drop_log.size() != 2) begin n_errors++; $display("FAIL cap_drops: got %0d want 2", drop_log.size()); end
        else begin
            n_checks++; if (drop_log[0] != 16) begin n_errors++; $display("FAIL cap_first_drop: after %0d acks want 16", drop_log[0]); end
            n_checks++; if (drop_log[1] != 20) begin n_errors++; $display("FAIL cap_second_drop: after %0d acks want 20", drop_log[1]); end
        end
        n_checks++;
        if (grant_log.size() != 2 || grant_log[0] !== 4'b0100 || grant_log[1] !== 4'b0100) begin
            n_errors++;
            $display("FAIL cap_regrant: got %0d grants want two of 0100", grant_log.size());
        end
        $display("test_max_bytes done");
    endtask

    task automatic test_timeout();
        int n, k;
        bit seen;
        tx_mode = MODE_DEAD;
        clear_logs();
        @(negedge clk);
        push_byte(0, 8'h77, 1'b1);
        n = 0;
        while (!tx_send && n < 20) begin @(negedge clk); n++; end
        k = 0;
        seen = 0;
        for (int i = 0; i < TIMEOUT + 10; i++) begin
            if (tx_send) k++;
            if (err_timeout) begin seen = 1; break; end
            @(negedge clk);
        end
        n_checks++; if (!seen || k != TIMEOUT) begin n_errors++; $display("FAIL tmo_cycle: err seen=%0d at SEND cycle %0d want 1 at %0d", seen, k, TIMEOUT); end
        n_checks++; if (tx_send !== 1'b1) begin n_errors++; $display("FAIL tmo_send_at_err: got %b want 1", tx_send); end
        @(negedge clk);
        n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL tmo_pulse_width: got %b want 0", err_timeout); end
        n_checks++; if (tx_send !== 1'b0) begin n_errors++; $display("FAIL tmo_send_drop: got %b want 0", tx_send); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_errors++; $display("FAIL tmo_idle: busy %b grant %b want 0 0000", busy, grant); end
        wait_done(50, "tmo");
        $display("test_timeout done");
    endtask

    task automatic test_abort();
        reset_dut();
        tx_mode = MODE_STUB;
        clear_logs();
        push_byte(0, 8'hE1, 1'b0);
        wait_done(200, "abort");
        repeat (10) @(negedge clk);
        n_checks++; if (ack_total != 1) begin n_errors++; $display("FAIL abort_acks: got %0d want 1", ack_total); end
        n_checks++; if (grant !== 4'b0000) begin n_errors++; $display("FAIL abort_grant: got %b want 0000", grant); end
        clear_logs();
        push_byte(0, 8'hE2, 1'b1);
        push_byte(1, 8'hE3, 1'b1);
        wait_done(200, "abort_ptr");
        n_checks++;
        if (grant_log.size() != 2 || grant_log[0] !== 4'b0010) begin
            n_errors++;
            $display("FAIL abort_ptr: %0d grants, first %b want 0010", grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 4'b0000);
        end
        $display("test_abort done");
    endtask

    task automatic test_reset_mid();
        int n, rises;
        logic prev;
        reset_dut();
        tx_mode  = MODE_STUB;
        stub_lat = 20;
        push_byte(2, 8'hC0, 1'b1);
        wait_done(200, "rm_pre");
        push_byte(2, 8'hC1, 1'b0);
        push_byte(2, 8'hC2, 1'b0);
        push_byte(2, 8'hC3, 1'b1);
        rises = 0; prev = 1'b0; n = 0;
        while (rises < 2 && n < 300) begin
            @(negedge clk);
            if (tx_send && !prev) rises++;
            prev = tx_send;
            n++;
        end
        n_checks++; if (rises != 2 || tx_data !== 8'hC2) begin n_errors++; $display("FAIL rm_second_byte: rises %0d data %h want 2 c2", rises, tx_data); end
        rst = 1'b1;
        flush_req = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_send !== 1'b0) begin n_errors++; $display("FAIL rm_send: got %b want 0", tx_send); end
        n_checks++; if (grant !== 4'b0000) begin n_errors++; $display("FAIL rm_grant: got %b want 0000", grant); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_checks++; if (byte_ack !== 4'b0000 || err_timeout !== 1'b0) begin n_errors++; $display("FAIL rm_pulses: ack %b err %b want 0000 0", byte_ack, err_timeout); end
        flush_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        stub_lat = 2;
        clear_logs();
        push_byte(0, 8'h5A, 1'b1);
        push_byte(3, 8'h5B, 1'b1);
        wait_done(200, "rm_post");
        n_checks++;
        if (grant_log.size() != 2 || grant_log[0] !== 4'b0001 || ack_data_log[0] !== 8'h5A) begin
            n_errors++;
            $display("FAIL rm_ptr_reset: %0d grants, first %b data %h want 0001 5a", grant_log.size(),
                     (grant_log.size() > 0) ? grant_log[0] : 4'b0000, (ack_data_log.size() > 0) ? ack_data_log[0] : 8'h00);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_max_bytes();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
